// File: rtl/key_conditioner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : key_conditioner_if
// Brief    : Raw key input and conditioned outputs of one push-button channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface key_conditioner_if;
    logic key_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output key_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  key_n,
        output pressed,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : key_conditioner
// Brief    : Synchronise, debounce and pulse-encode one active-low push-button.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    key_conditioner_if.slave  kif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] c_DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] c_LONG_LAST = LW'(LONG_CYCLES - 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] S_HELD         = 3'd2;
    localparam logic [2:0] S_LONG_HELD    = 3'd3;
    localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

    logic          r_sync1;
    logic          r_sync2;
    logic [2:0]    r_state;
    logic [DW-1:0] r_deb_cnt;
    logic [LW-1:0] r_long_cnt;
    logic          r_from_long;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_long_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_state         <= S_IDLE;
            r_deb_cnt       <= '0;
            r_long_cnt      <= '0;
            r_from_long     <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_sync1         <= kif.key_n;
            r_sync2         <= r_sync1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state   <= S_PRESS_WAIT;
                        r_deb_cnt <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        r_state       <= S_HELD;
                        r_press_pulse <= 1'b1;
                        r_pressed     <= 1'b1;
                        r_long_cnt    <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DW'(1);
                    end
                end
                // A high sample freezes the hold count until the release resolves.
                S_HELD: begin
                    if (r_sync2) begin
                        r_state     <= S_RELEASE_WAIT;
                        r_deb_cnt   <= '0;
                        r_from_long <= 1'b0;
                    end else if (r_long_cnt == c_LONG_LAST) begin
                        r_state      <= S_LONG_HELD;
                        r_long_pulse <= 1'b1;
                        r_long_cnt   <= r_long_cnt + LW'(1);
                    end else begin
                        r_long_cnt <= r_long_cnt + LW'(1);
                    end
                end
                S_LONG_HELD: begin
                    if (r_sync2) begin
                        r_state     <= S_RELEASE_WAIT;
                        r_deb_cnt   <= '0;
                        r_from_long <= 1'b1;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= r_from_long ? S_LONG_HELD : S_HELD;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        r_state         <= S_IDLE;
                        r_release_pulse <= 1'b1;
                        r_pressed       <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kif.pressed       = r_pressed;
    assign kif.press_pulse   = r_press_pulse;
    assign kif.release_pulse = r_release_pulse;
    assign kif.long_pulse    = r_long_pulse;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_key_conditioner
// Brief    : Directed and randomised bench for key_conditioner with a run-length model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic reset;
    logic key_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cnt_press = 0;
    int   cnt_release = 0;
    int   cnt_long = 0;

    always #5 clk = ~clk;

    key_conditioner_if kif ();
    assign kif.key_n = key_n;

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    // Reference: a level change is accepted once the synchronised key has
    // disagreed with the accepted level for D+1 consecutive edges; hold time
    // accrues on every edge the key stays down with no pending release.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0, m_fired = 1'b0;
    int   m_run = 0, m_hold = 0;
    logic exp_pressed = 1'b0, exp_press = 1'b0, exp_release = 1'b0, exp_long = 1'b0;

    always @(posedge clk) begin
        logic s2_now;
        logic disagree;
        int   prev_run;
        cyc = cyc + 1;
        exp_press   = 1'b0;
        exp_release = 1'b0;
        exp_long    = 1'b0;
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_fired = 1'b0;
            m_run = 0; m_hold = 0;
        end else begin
            s2_now   = m_s2;
            m_s2     = m_s1;
            m_s1     = key_n;
            disagree = (!s2_now) != m_lvl;
            prev_run = m_run;
            m_run    = disagree ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    exp_press = 1'b1;
                    m_hold    = 0;
                    m_fired   = 1'b0;
                end else begin
                    exp_release = 1'b1;
                end
            end else if (m_lvl && !disagree && prev_run == 0 && !m_fired) begin
                m_hold = m_hold + 1;
                if (m_hold == L) begin
                    exp_long = 1'b1;
                    m_fired  = 1'b1;
                end
            end
        end
        exp_pressed = m_lvl;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check_bit("pressed",       kif.pressed,       exp_pressed);
        check_bit("press_pulse",   kif.press_pulse,   exp_press);
        check_bit("release_pulse", kif.release_pulse, exp_release);
        check_bit("long_pulse",    kif.long_pulse,    exp_long);
        check_bit("pulse_exclusive",
                  (int'(kif.press_pulse) + int'(kif.release_pulse) + int'(kif.long_pulse)) > 1, 1'b0);
        cnt_press   += int'(kif.press_pulse === 1'b1);
        cnt_release += int'(kif.release_pulse === 1'b1);
        cnt_long    += int'(kif.long_pulse === 1'b1);
    end

    // Called at a negedge: key_n is sampled by the next n rising edges.
    task automatic drive(input logic v, input int n);
        key_n = v;
        repeat (n) @(negedge clk);
    endtask

    // which: 0 press, 1 release, 2 long. Returns the edge index, or -1 on timeout.
    task automatic wait_pulse(input int which, input int limit, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && kif.press_pulse === 1'b1) ||
                (which == 1 && kif.release_pulse === 1'b1) ||
                (which == 2 && kif.long_pulse === 1'b1)) begin
                edge_no = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, ep, el, er, snap_p, snap_r, snap_l;
        key_n = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_bit("reset_pressed", kif.pressed, 1'b0);
        check_bit("reset_press_pulse", kif.press_pulse, 1'b0);

        // Clean press sampled first at edge 10.
        while (cyc < 9) @(negedge clk);
        key_n = 1'b0;
        e0 = cyc + 1;
        check_int("clean_first_edge", e0, 10);
        wait_pulse(0, 20, ep);
        check_int("clean_press_edge", ep, 16);
        check_bit("clean_pressed", kif.pressed, 1'b1);

        // Long press fires once, L edges after the press pulse.
        wait_pulse(2, 20, el);
        check_int("long_edge", el, 26);
        drive(1'b0, 20);
        #1;
        check_int("long_count_hold", cnt_long, 1);
        check_int("release_count_hold", cnt_release, 0);

        // Release with bounce: high 2, low 1, then high.
        drive(1'b1, 2);
        drive(1'b0, 1);
        key_n = 1'b1;
        er = cyc + 1;
        wait_pulse(1, 20, el);
        check_int("release_edge", el, er + 6);
        check_bit("release_pressed", kif.pressed, 1'b0);
        drive(1'b1, 15);
        #1;
        check_int("release_count", cnt_release, 1);
        check_int("no_second_long", cnt_long, 1);

        // Short tap below the debounce threshold.
        snap_p = cnt_press; snap_r = cnt_release; snap_l = cnt_long;
        drive(1'b0, 3);
        drive(1'b1, 20);
        #1;
        check_int("tap_press", cnt_press, snap_p);
        check_int("tap_release", cnt_release, snap_r);
        check_int("tap_long", cnt_long, snap_l);
        check_bit("tap_pressed", kif.pressed, 1'b0);

        // Press bounce: low 3, high 1, then low.
        snap_p = cnt_press;
        drive(1'b0, 3);
        drive(1'b1, 1);
        key_n = 1'b0;
        e0 = cyc + 1;
        wait_pulse(0, 20, ep);
        check_int("bounce_press_edge", ep, e0 + 6);
        drive(1'b0, 2);
        #1;
        check_int("bounce_press_count", cnt_press, snap_p + 1);

        // Reset mid-hold with the key still down.
        snap_r = cnt_release;
        reset = 1'b1;
        @(negedge clk);
        check_bit("midreset_pressed", kif.pressed, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        e0 = cyc + 1;
        wait_pulse(0, 20, ep);
        check_int("midreset_press_edge", ep, e0 + 6);
        #1;
        check_int("midreset_no_release", cnt_release, snap_r);

        // Randomised segments with occasional resets; the model checks every edge.
        @(negedge clk);
        for (int s = 0; s < 300; s++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 30))
                                              : int'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), len);
        end
        drive(1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
